kuznechik_decoder: RTL
======================

# kuznechik_decoder

Iterative GOST R 34.12-2015 (Kuznechik) block decryptor: the inverse of `KuznechikEncoder`, recovering a 128-bit plaintext from a 128-bit ciphertext under a 256-bit key. It sits on the receive side of the cipher datapath and shares the S-box, inverse S-box and L-constant package with the encoder. Work is spread over many cycles: an in-block key schedule, then nine decryption rounds. It uses a valid/ready handshake on both input and output.

## Interface
Parameters: none; the block has fixed widths.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `encoded` and `key` are valid.
- `in_ready`  out  1  the block is ready to accept a job.
- `encoded`  in  128  ciphertext; bit 127 is the first byte's MSB.
- `key`  in  256  master key; `K1 = key[255:128]`, `K2 = key[127:0]`.
- `out_valid`  out  1  `block` holds a result.
- `out_ready`  in  1  the sink accepts the result.
- `block`  out  128  decrypted plaintext.

## Operation
- Accept: a job is accepted when `in_valid && in_ready`. On acceptance the block registers `encoded` and `key`.
- FSM states: IDLE → EXPAND → WHITEN → ROUND → DONE → IDLE.
- IDLE:
  - `in_ready` = 1.
  - Acceptance moves to EXPAND, or to WHITEN on a cache hit (see Configuration).
- EXPAND:
  - 32 Feistel steps, one per cycle, counter `j` = 1..32.
  - Each step: `(a,b) ← (L(S(a ⊕ C_j)) ⊕ b, a)`, where `C_j = L(vec128(j))` is taken from the package constant table.
  - After steps 8, 16, 24 and 32, store the pair as `K3/K4`, `K5/K6`, `K7/K8` and `K9/K10` respectively.
  - `K1` and `K2` are stored at acceptance.
- WHITEN: one cycle, `state ← encoded ⊕ K10`.
- ROUND:
  - Nine cycles, `i` = 9 down to 1.
  - Each cycle: `state ← S⁻¹(L⁻¹(state)) ⊕ K_i`.
  - `L⁻¹` is 16 combinational applications of `R⁻¹` over GF(2⁸) with polynomial x⁸+x⁷+x⁶+x+1 (0x1C3).
- DONE:
  - `block ← state` and `out_valid` = 1.
  - `block` is held stable until `out_ready`.
  - On `out_valid && out_ready`, return to IDLE.
- `in_valid` outside IDLE is ignored, and the inputs are not sampled.
- Reset values:
  - `in_ready` = 1, `out_valid` = 0, `block` = 0.
  - FSM = IDLE, all round-key registers = 0, cache-valid = 0.
- Reset mid-operation: any in-flight job is discarded with no output, and all outputs take their reset values on the next edge.

## Timing
- Handshake accepted at edge T:
  - cache miss: `out_valid` rises at edge T+42 (32 EXPAND + 1 WHITEN + 9 ROUND).
  - cache hit: `out_valid` rises at edge T+10.
- Output handshake at edge U: `out_valid` falls at U and `in_ready` rises at U. The next acceptance is at U+1 at the earliest.
- Throughput: one block per 43 cycles (miss) or 11 cycles (hit), with `out_ready` tied high.
- No combinational path from any input to any output. `in_ready` depends on FSM state only.

## Configuration
- `KUZNECHIK_DECODER_KEY_CACHE_EN`:
  - Defined:
    - The block keeps `K1..K10` plus a cache-valid bit.
    - If cache-valid is set and the accepted `key` equals the stored `K1||K2`, EXPAND is skipped (IDLE → WHITEN).
    - Cache-valid is set at the end of EXPAND and cleared by `rst`.
    - A differing key runs EXPAND and overwrites the cache.
  - Undefined: EXPAND runs on every job, and the latency is always 42.

## Test plan
- GOST vector:
  - `key` = 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef, `encoded` = 7f679d90bebc24305a468d42b9d4edcd.
  - Required: `block` = 1122334455667700ffeeddccbbaa9988, with `out_valid` at T+42.
- Back-pressure: run the GOST vector with `out_ready` = 0 for 20 cycles. `block` and `out_valid` must stay constant, `in_ready` must stay 0, and the job completes on the first `out_ready` = 1.
- Cache (macro defined):
  - Run the GOST vector twice back-to-back with the same key. The second result must be at T+10 with the identical plaintext.
  - Then flip `key[0]`. Latency returns to 42.
  - Without the macro, both runs take 42 cycles.
- Reset mid-EXPAND: assert `rst` at cycle 15 after acceptance. Next edge: `out_valid` = 0, `in_ready` = 1, `block` = 0, and no result is ever produced. A fresh GOST job then decodes correctly at 42 cycles.
- Busy-input ignore: toggle `in_valid` with garbage `encoded`/`key` during ROUND. The GOST result must be unchanged.
- Round trip: 200 random block/key pairs through `KuznechikEncoder` then `kuznechik_decoder`. The decoder's `block` must equal the original block in every case.

Source files
------------

// File: rtl/kuznechik_decoder_if.sv
// +------------------------------------------------------------------+
// | kuznechik_decoder_if                                             |
// | Job-in / result-out handshake bundle for the Kuznechik decryptor |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface kuznechik_decoder_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] encoded;
    logic [255:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] block;

    modport master (
        output in_valid, encoded, key, out_ready,
        input  in_ready, out_valid, block
    );

    modport slave (
        input  in_valid, encoded, key, out_ready,
        output in_ready, out_valid, block
    );
endinterface

`default_nettype wire

// File: rtl/kuznechik_decoder.sv
// +------------------------------------------------------------------+
// | kuznechik_decoder                                                |
// | Iterative GOST R 34.12-2015 block decryptor: 32-step key         |
// | expansion, one whitening cycle, nine inverse rounds.             |
// | Optional round-key cache: KUZNECHIK_DECODER_KEY_CACHE_EN         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module kuznechik_decoder (
    input wire                 clk,
    input wire                 rst,
    kuznechik_decoder_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_EXPAND = 3'd1;
    localparam logic [2:0] c_ST_WHITEN = 3'd2;
    localparam logic [2:0] c_ST_ROUND  = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    // pi[x] lives at bits [2047-8x -: 8]
    localparam logic [2047:0] c_SBOX = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    // Linear-map coefficient for byte k sits at [8k +: 8]
    localparam logic [127:0] c_LVEC = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        return c_SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] lin(input logic [127:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 0; k < 16; k++) acc = acc ^ gf_mul(v[8*k +: 8], c_LVEC[8*k +: 8]);
        return acc;
    endfunction

    function automatic logic [127:0] l_fwd(input logic [127:0] v);
        logic [127:0] t;
        t = v;
        for (int k = 0; k < 16; k++) t = {lin(t), t[127:8]};
        return t;
    endfunction

    function automatic logic [127:0] l_inv(input logic [127:0] v);
        logic [127:0] t;
        t = v;
        for (int k = 0; k < 16; k++) t = {t[119:0], lin({t[119:0], t[127:120]})};
        return t;
    endfunction

    function automatic logic [2047:0] gen_sinv();
        logic [2047:0] t;
        t = '0;
        for (int i = 0; i < 256; i++) t[2047 - 8*int'(sb(8'(i))) -: 8] = 8'(i);
        return t;
    endfunction

    // C_j = L(vec128(j)) at [(j-1)*128 +: 128]
    function automatic logic [4095:0] gen_ctab();
        logic [4095:0] t;
        t = '0;
        for (int j = 1; j <= 32; j++) t[(j-1)*128 +: 128] = l_fwd(128'(j));
        return t;
    endfunction

    localparam logic [2047:0] c_SINV = gen_sinv();
    localparam logic [4095:0] c_CTAB = gen_ctab();

    function automatic logic [127:0] s_fwd(input logic [127:0] v);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = sb(v[8*k +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] s_inv(input logic [127:0] v);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = c_SINV[2047 - 8*int'(v[8*k +: 8]) -: 8];
        return o;
    endfunction

    logic [2:0]   r_state;
    logic [2:0]   w_next;
    logic [4:0]   r_cnt;
    logic [127:0] r_enc;
    logic [127:0] r_a;
    logic [127:0] r_b;
    logic [127:0] r_st;
    logic [127:0] r_block;
    logic [127:0] r_rk [0:9];
    logic         w_accept;
    logic         w_hit;
    logic [127:0] w_exp_a;
    logic [127:0] w_rnd;
    logic [3:0]   w_kidx;

`ifdef KUZNECHIK_DECODER_KEY_CACHE_EN
    logic r_cache_vld;
    assign w_hit = r_cache_vld && (bus.key == {r_rk[0], r_rk[1]});
`else
    assign w_hit = 1'b0;
`endif

    assign w_accept = bus.in_valid && (r_state == c_ST_IDLE);
    assign w_exp_a  = l_fwd(s_fwd(r_a ^ c_CTAB[int'(r_cnt)*128 +: 128])) ^ r_b;
    assign w_rnd    = s_inv(l_inv(r_st)) ^ r_rk[r_cnt[3:0]];
    // Pair slot for K3/K4 .. K9/K10, written after every eighth step
    assign w_kidx   = {1'b0, r_cnt[4:3], 1'b0} + 4'd2;

    assign bus.in_ready  = (r_state == c_ST_IDLE);
    assign bus.out_valid = (r_state == c_ST_DONE);
    assign bus.block     = r_block;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_next = w_hit ? c_ST_WHITEN : c_ST_EXPAND;
            c_ST_EXPAND: if (r_cnt == 5'd31) w_next = c_ST_WHITEN;
            c_ST_WHITEN: w_next = c_ST_ROUND;
            c_ST_ROUND:  if (r_cnt == 5'd0) w_next = c_ST_DONE;
            c_ST_DONE:   if (bus.out_ready) w_next = c_ST_IDLE;
            default:     w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_enc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_st    <= '0;
            r_block <= '0;
            for (int k = 0; k < 10; k++) r_rk[k] <= '0;
`ifdef KUZNECHIK_DECODER_KEY_CACHE_EN
            r_cache_vld <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_enc <= bus.encoded;
                        r_cnt <= '0;
                        if (!w_hit) begin
                            r_rk[0] <= bus.key[255:128];
                            r_rk[1] <= bus.key[127:0];
                            r_a     <= bus.key[255:128];
                            r_b     <= bus.key[127:0];
`ifdef KUZNECHIK_DECODER_KEY_CACHE_EN
                            r_cache_vld <= 1'b0;
`endif
                        end
                    end
                end
                c_ST_EXPAND: begin
                    r_a   <= w_exp_a;
                    r_b   <= r_a;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt[2:0] == 3'd7) begin
                        r_rk[w_kidx]        <= w_exp_a;
                        r_rk[w_kidx + 4'd1] <= r_a;
                    end
`ifdef KUZNECHIK_DECODER_KEY_CACHE_EN
                    if (r_cnt == 5'd31) r_cache_vld <= 1'b1;
`endif
                end
                c_ST_WHITEN: begin
                    r_st  <= r_enc ^ r_rk[9];
                    r_cnt <= 5'd8;
                end
                c_ST_ROUND: begin
                    r_st  <= w_rnd;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) r_block <= w_rnd;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
